// File: rtl/pctrl_ser_if.sv
// pctrl_ser_if: command/status bundle of the serial peripheral-control decoder.
// The master side owns the instance address and the serial line. The slave
// side (the decoder) returns the decoded opcode and its status flags.
interface pctrl_ser_if #(
    parameter int ADDR_W = 8,
    parameter int OP_W   = 3
);
    logic [ADDR_W-1:0] address;
    logic              rx;
    logic [OP_W-1:0]   opcode;
    logic              op_valid;
    logic              busy;
    logic              bcast;
    logic              frame_err;

    modport master (
        output address,
        output rx,
        input  opcode,
        input  op_valid,
        input  busy,
        input  bcast,
        input  frame_err
    );

    modport slave (
        input  address,
        input  rx,
        output opcode,
        output op_valid,
        output busy,
        output bcast,
        output frame_err
    );
endinterface

// File: rtl/pctrl_ser.sv
// pctrl_ser: serial peripheral-control decoder.
// Frames arrive LSB first on an idle-high line:
//   start(0), ADDR_W address bits, OP_W opcode bits, [parity], stop(1).
// Every bit is sampled in the middle of its bit period. A frame whose address
// matches this instance, or the all-ones broadcast address when broadcast is
// enabled, presents its opcode for EXEC_CYCLES cycles. A frame for another
// address is counted out without decoding, so that its opcode bits can never
// be mistaken for a start bit.
// Optional feature: define PCTRL_SER_PARITY_EN to add one even-parity bit after
// the opcode field. It covers every address and opcode bit.
// ADDR_W and OP_W must be at least 2.
module pctrl_ser #(
    parameter int ADDR_W       = 8,
    parameter int OP_W         = 3,
    parameter int CLKS_PER_BIT = 1,
    parameter int EXEC_CYCLES  = 32,
    parameter int BCAST_EN_VAL = 1
) (
    input  logic           clk,
    input  logic           Rst,
    pctrl_ser_if.slave     bus
);

    localparam int HALF      = CLKS_PER_BIT / 2;
    localparam int CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int EX_W      = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
`ifdef PCTRL_SER_PARITY_EN
    localparam int PAR_BITS  = 1;
`else
    localparam int PAR_BITS  = 0;
`endif
    // A skipped frame still has its opcode, optional parity and stop bits to come.
    localparam int SKIP_BITS = OP_W + PAR_BITS + 1;
    localparam int BIT_W     = $clog2(ADDR_W + OP_W + 3);

    localparam logic [CNT_W-1:0]  BIT_RELOAD  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  HALF_RELOAD = (HALF > 0) ? CNT_W'(HALF - 1) : {CNT_W{1'b0}};
    localparam logic [EX_W-1:0]   EXEC_RELOAD = EX_W'(EXEC_CYCLES - 1);
    localparam logic [BIT_W-1:0]  ADDR_LAST   = BIT_W'(ADDR_W - 1);
    localparam logic [BIT_W-1:0]  OP_LAST     = BIT_W'(OP_W - 1);
    localparam logic [BIT_W-1:0]  SKIP_LAST   = BIT_W'(SKIP_BITS - 1);
    localparam logic [OP_W-1:0]   NO_OP       = {OP_W{1'b1}};
    localparam logic [ADDR_W-1:0] BCAST_ADDR  = {ADDR_W{1'b1}};
    localparam bit                BCAST_ON    = (BCAST_EN_VAL != 0);
    // With one clock per bit there is no half period to wait: the start is taken at once.
    localparam bit                NO_HALF     = (HALF == 0);

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_START = 4'd1,
        ST_ADDR  = 4'd2,
        ST_OPC   = 4'd3,
`ifdef PCTRL_SER_PARITY_EN
        ST_PAR   = 4'd4,
`endif
        ST_STOP  = 4'd5,
        ST_SKIP  = 4'd6,
        ST_EXEC  = 4'd7
    } state_t;

`ifdef PCTRL_SER_PARITY_EN
    // Value of the even-parity bit for a given address and opcode.
    function automatic logic even_par(input logic [ADDR_W-1:0] a, input logic [OP_W-1:0] o);
        return ^{a, o};
    endfunction
`endif

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [BIT_W-1:0]  r_bit;
    logic [ADDR_W-1:0] r_addr_sh;
    logic [OP_W-1:0]   r_op_sh;
    logic [EX_W-1:0]   r_exec;
    logic              r_bhit;
    logic [OP_W-1:0]   r_opcode;
    logic              r_op_valid;
    logic              r_busy;
    logic              r_bcast;
    logic              r_frame_err;
`ifdef PCTRL_SER_PARITY_EN
    logic              r_par_ok;
    logic              w_par_ok_nxt;
`endif

    state_t            w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [BIT_W-1:0]  w_bit_nxt;
    logic [ADDR_W-1:0] w_addr_sh_nxt;
    logic [OP_W-1:0]   w_op_sh_nxt;
    logic [EX_W-1:0]   w_exec_nxt;
    logic              w_bhit_nxt;
    logic [OP_W-1:0]   w_opcode_nxt;
    logic              w_op_valid_nxt;
    logic              w_busy_nxt;
    logic              w_bcast_nxt;
    logic              w_frame_err_nxt;

    logic              w_tick;
    logic [ADDR_W-1:0] w_addr_full;
    logic [OP_W-1:0]   w_op_full;
    logic              w_self_hit;
    logic              w_bc_hit;
    logic              w_stop_ok;

    // w_tick marks the sample point of the current bit period.
    assign w_tick      = (r_cnt == {CNT_W{1'b0}});
    // The shift registers together with the bit now on the line form the complete field.
    assign w_addr_full = {bus.rx, r_addr_sh[ADDR_W-1:1]};
    assign w_op_full   = {bus.rx, r_op_sh[OP_W-1:1]};
    assign w_self_hit  = (w_addr_full == bus.address);
    assign w_bc_hit    = BCAST_ON && (w_addr_full == BCAST_ADDR);
`ifdef PCTRL_SER_PARITY_EN
    assign w_stop_ok   = bus.rx & r_par_ok;
`else
    assign w_stop_ok   = bus.rx;
`endif

    assign bus.opcode    = r_opcode;
    assign bus.op_valid  = r_op_valid;
    assign bus.busy      = r_busy;
    assign bus.bcast     = r_bcast;
    assign bus.frame_err = r_frame_err;

    // Next-state and next-output decode of the frame receiver.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_bit_nxt       = r_bit;
        w_addr_sh_nxt   = r_addr_sh;
        w_op_sh_nxt     = r_op_sh;
        w_exec_nxt      = r_exec;
        w_bhit_nxt      = r_bhit;
        w_opcode_nxt    = r_opcode;
        w_op_valid_nxt  = 1'b0;
        w_busy_nxt      = r_busy;
        w_bcast_nxt     = r_bcast;
        w_frame_err_nxt = 1'b0;
`ifdef PCTRL_SER_PARITY_EN
        w_par_ok_nxt    = r_par_ok;
`endif
        case (r_state)
            ST_IDLE: begin
                if (!bus.rx) begin
                    if (NO_HALF) begin
                        w_state_nxt = ST_ADDR;
                        w_cnt_nxt   = BIT_RELOAD;
                        w_bit_nxt   = {BIT_W{1'b0}};
                        w_busy_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ST_START;
                        w_cnt_nxt   = HALF_RELOAD;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_START: begin
                if (!w_tick) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else if (bus.rx) begin
                    // The line went high again before mid-bit: a glitch, not a start.
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_ADDR;
                    w_cnt_nxt   = BIT_RELOAD;
                    w_bit_nxt   = {BIT_W{1'b0}};
                    w_busy_nxt  = 1'b1;
                end
            end
            ST_ADDR: begin
                if (!w_tick) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else begin
                    w_cnt_nxt     = BIT_RELOAD;
                    w_addr_sh_nxt = w_addr_full;
                    if (r_bit == ADDR_LAST) begin
                        w_bit_nxt  = {BIT_W{1'b0}};
                        w_bhit_nxt = w_bc_hit;
                        if (w_self_hit || w_bc_hit) begin
                            w_state_nxt = ST_OPC;
                        end else begin
                            w_state_nxt = ST_SKIP;
                        end
                    end else begin
                        w_bit_nxt = r_bit + BIT_W'(1);
                    end
                end
            end
            ST_OPC: begin
                if (!w_tick) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else begin
                    w_cnt_nxt   = BIT_RELOAD;
                    w_op_sh_nxt = w_op_full;
                    if (r_bit == OP_LAST) begin
                        w_bit_nxt = {BIT_W{1'b0}};
`ifdef PCTRL_SER_PARITY_EN
                        w_state_nxt = ST_PAR;
`else
                        w_state_nxt = ST_STOP;
`endif
                    end else begin
                        w_bit_nxt = r_bit + BIT_W'(1);
                    end
                end
            end
`ifdef PCTRL_SER_PARITY_EN
            ST_PAR: begin
                if (!w_tick) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else begin
                    // The verdict is held until the stop bit, where frame_err is reported.
                    w_cnt_nxt    = BIT_RELOAD;
                    w_par_ok_nxt = (bus.rx == even_par(r_addr_sh, r_op_sh));
                    w_state_nxt  = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (!w_tick) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else if (w_stop_ok) begin
                    w_state_nxt    = ST_EXEC;
                    w_exec_nxt     = EXEC_RELOAD;
                    w_opcode_nxt   = r_op_sh;
                    w_op_valid_nxt = 1'b1;
                    w_bcast_nxt    = r_bhit;
                end else begin
                    w_state_nxt     = ST_IDLE;
                    w_frame_err_nxt = 1'b1;
                    w_busy_nxt      = 1'b0;
                end
            end
            ST_SKIP: begin
                if (!w_tick) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else if (r_bit == SKIP_LAST) begin
                    // The stop bit of a foreign frame is ignored, whatever its value.
                    w_state_nxt = ST_IDLE;
                    w_bit_nxt   = {BIT_W{1'b0}};
                    w_busy_nxt  = 1'b0;
                end else begin
                    w_cnt_nxt = BIT_RELOAD;
                    w_bit_nxt = r_bit + BIT_W'(1);
                end
            end
            ST_EXEC: begin
                // The op_valid cycle counts as the first of the EXEC_CYCLES cycles.
                if (r_exec == {EX_W{1'b0}}) begin
                    w_state_nxt  = ST_IDLE;
                    w_opcode_nxt = NO_OP;
                    w_bcast_nxt  = 1'b0;
                    w_busy_nxt   = 1'b0;
                end else begin
                    w_exec_nxt = r_exec - EX_W'(1);
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_cnt_nxt     = {CNT_W{1'b0}};
                w_bit_nxt     = {BIT_W{1'b0}};
                w_addr_sh_nxt = {ADDR_W{1'b0}};
                w_op_sh_nxt   = {OP_W{1'b0}};
                w_exec_nxt    = {EX_W{1'b0}};
                w_bhit_nxt    = 1'b0;
                w_opcode_nxt  = NO_OP;
                w_busy_nxt    = 1'b0;
                w_bcast_nxt   = 1'b0;
`ifdef PCTRL_SER_PARITY_EN
                w_par_ok_nxt  = 1'b0;
`endif
            end
        endcase
    end

    // State, counter, shift and output registers; reset aborts any frame or execute window.
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= {CNT_W{1'b0}};
            r_bit       <= {BIT_W{1'b0}};
            r_addr_sh   <= {ADDR_W{1'b0}};
            r_op_sh     <= {OP_W{1'b0}};
            r_exec      <= {EX_W{1'b0}};
            r_bhit      <= 1'b0;
            r_opcode    <= NO_OP;
            r_op_valid  <= 1'b0;
            r_busy      <= 1'b0;
            r_bcast     <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef PCTRL_SER_PARITY_EN
            r_par_ok    <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bit       <= w_bit_nxt;
            r_addr_sh   <= w_addr_sh_nxt;
            r_op_sh     <= w_op_sh_nxt;
            r_exec      <= w_exec_nxt;
            r_bhit      <= w_bhit_nxt;
            r_opcode    <= w_opcode_nxt;
            r_op_valid  <= w_op_valid_nxt;
            r_busy      <= w_busy_nxt;
            r_bcast     <= w_bcast_nxt;
            r_frame_err <= w_frame_err_nxt;
`ifdef PCTRL_SER_PARITY_EN
            r_par_ok    <= w_par_ok_nxt;
`endif
        end
    end

endmodule

// File: doc/pctrl_ser.md
Name: pctrl_ser

Overview:
- Parametrised successor to the serial peripheral-control decoder.
- Receives address/opcode command frames on a single-wire serial line (rx) at a configurable oversampling rate.
- On address or broadcast match, presents the decoded opcode to the datapath for a fixed execute window, then returns to NO_OP.
- Adds mid-bit sampling, false-start rejection, stop-bit checking, mismatch frame skipping and an execute-start strobe.

Parameters:
- ADDR_W, 8: address field width (bits).
- OP_W, 3: opcode field width (bits); NO_OP is all ones.
- CLKS_PER_BIT, 1: clock cycles per serial bit; must be >= 1.
- EXEC_CYCLES, 32: cycles the opcode is held after a matched frame; must be >= 1.
- BCAST_EN_VAL, 1: 1 means the all-ones address matches every instance; 0 disables broadcast.

Ports:
- clk, input, 1: system clock.
- Rst, input, 1: asynchronous, active-high reset.
- address, input, ADDR_W: this instance's address; compared when the last address bit is sampled.
- rx, input, 1: serial line, idle high, already synchronised upstream.
- opcode, output reg, OP_W: current opcode; NO_OP (all ones) when not executing.
- op_valid, output reg, 1: one-cycle pulse on the first EXEC cycle.
- busy, output reg, 1: high from confirmed start bit until return to IDLE.
- bcast, output reg, 1: high during EXEC when the frame matched via the broadcast address.
- frame_err, output reg, 1: one-cycle pulse on stop-bit (or parity) failure.

Behaviour:
- Reset (async, Rst=1): state=IDLE, opcode=all ones, op_valid=0, busy=0, bcast=0, frame_err=0, all counters and shift registers 0. Reset mid-frame or mid-EXEC aborts immediately, with no further output.
- Frame format, LSB first: start(0), ADDR_W address bits, OP_W opcode bits, [parity], stop(1).
- Timing: let d be the first IDLE cycle with rx=0, and H=CLKS_PER_BIT/2 (integer).
  - Start bit is re-checked at d+H. If H=0 the start is confirmed at d.
  - Payload bit k (k=0..) is sampled at d+H+(k+1)*CLKS_PER_BIT.
- States:
  - IDLE: wait for rx=0.
  - START: wait H cycles. rx=1 at the check means a false start: return to IDLE, no error, busy stays 0.
  - ADDR: shift in ADDR_W bits. After the last bit, compare against address (and all ones if BCAST_EN_VAL). Match goes to OPC. Mismatch goes to SKIP.
  - OPC: shift in OP_W bits, then go to PAR if enabled, else STOP.
  - PAR: sample the parity bit (see Optional Feature).
  - STOP: sample the stop bit.
    - rx=1: load opcode and bcast on the next edge, op_valid=1 for that cycle, go to EXEC.
    - rx=0: pulse frame_err for one cycle, go to IDLE; opcode stays NO_OP.
  - SKIP: count out the remaining OP_W (+parity) +stop bit periods without decoding, then go to IDLE. No error is reported and the stop value is ignored. This stops opcode bits being taken as start bits.
  - EXEC: hold opcode for exactly EXEC_CYCLES cycles, counted from the op_valid cycle. Then opcode=NO_OP, bcast=0, busy=0, state=IDLE. rx is ignored throughout EXEC.
- busy=1 in every state except IDLE and an unconfirmed START.
- A new start bit is accepted on the first IDLE cycle after EXEC or SKIP.
- Counters: the bit-period counter is sized for CLKS_PER_BIT-1; the EXEC counter is sized for EXEC_CYCLES-1. Neither wraps: each reloads on state entry.
- Any undefined state encoding recovers to IDLE with outputs at reset values.

Optional Feature:
- Macro: PCTRL_SER_PARITY_EN.
- Defined:
  - The PAR state exists. One even-parity bit follows the opcode field; it covers all address and opcode bits.
  - A parity mismatch pulses frame_err at the stop-bit sample and gives no EXEC.
  - SKIP also counts the parity bit.
- Undefined:
  - No parity bit and no PAR state; frames are one bit shorter.
  - frame_err reports stop-bit failures only.

Test Plan:
- CLKS_PER_BIT=4, address=8'h5A; send addr 5A, op 3'h5, stop 1 -> op_valid pulses one cycle, opcode=5 for 32 cycles, then 7; busy falls with the return to 7.
- Same bench, address 8'h5B sent, op 3'h0 (whose bits contain 0s), followed immediately by a valid 5A/op 2 frame -> first frame gives no output and no frame_err; second frame executes opcode=2.
- rx low for 1 cycle only, CLKS_PER_BIT=4 -> false start; busy stays 0, state returns to IDLE, no frame_err.
- Valid 5A/op 3 frame with stop bit 0 -> frame_err one-cycle pulse, opcode stays 7, next frame accepted.
- Broadcast FF/op 4, BCAST_EN_VAL=1 -> opcode=4, bcast=1 for 32 cycles. With BCAST_EN_VAL=0 the same frame is ignored.
- Rst asserted mid-EXEC at cycle 10 -> opcode=7, busy=0, op_valid=0 immediately. With PCTRL_SER_PARITY_EN, flipping the parity bit gives frame_err and no EXEC.
